// File: rtl/pool_pkg.sv
// Shared types and helpers for the pooling stream block.
//   state_t      : controller state encoding
//   MODE_MAX/AVG : pooling mode encoding (mode input / latched mode)
//   acc_width    : accumulator entry width that cannot overflow for a KxK sum
//   cnt_width    : counter width for a 0..n-1 range (never below 1 bit)
package pool_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_MAX = 1'b0;
  localparam logic MODE_AVG = 1'b1;

  // A KxK sum of DW-bit values needs 2*log2(K) extra bits.
  function automatic int acc_width(int dw, int k);
    return dw + 2 * $clog2(k);
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_acc_buf.sv
// Per-output-column partial-result storage for one band of K input rows.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data (AW bits)
//   raddr : read index
//   rdata : combinational read data
// Contents are never reset; every window starts by overwriting its entry.
module pool_acc_buf #(
  parameter int AW    = 10,
  parameter int DEPTH = 3,
  parameter int IW    = 2
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [AW-1:0] wdata,
  input  logic [IW-1:0] raddr,
  output logic [AW-1:0] rdata
);

  logic [AW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pool_stream.sv
// Streaming non-overlapping KxK max/average pooling over a raster-order,
// channel-interleaved frame.
// Ports:
//   clk       : clock, rising edge
//   rstn      : synchronous reset, active-high
//   start     : frame start request (accepted only in IDLE)
//   mode      : 0 = max, 1 = average (latched on accepted start)
//   in_data   : input pixel, in_valid/in_ready handshake
//   out_data  : pooled result, out_valid/out_ready handshake
//   busy      : controller not idle
//   done      : one-cycle frame completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting the frame's H*W*C input beats
// DRAIN | last beat taken, waiting for the final output handshake
// DONE  | one-cycle completion pulse
module pool_stream
  import pool_pkg::*;
#(
  parameter int DW = 8,
  parameter int H  = 6,
  parameter int W  = 6,
  parameter int K  = 2,
  parameter int C  = 1
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          mode,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int AW    = acc_width(DW, K);
  localparam int SH    = 2 * $clog2(K);
  localparam int KB    = $clog2(K);
  localparam int DEPTH = (W / K) * C;
  localparam int IW    = cnt_width(DEPTH);
  localparam int CHW   = cnt_width(C);
  localparam int COLW  = cnt_width(W);
  localparam int ROWW  = cnt_width(H);

  state_t          state;
  logic            mode_q;
  logic [CHW-1:0]  ch;
  logic [COLW-1:0] col;
  logic [ROWW-1:0] row;

  logic            accept;
  logic            ch_last, col_last, row_last;
  logic            win_first, win_last;
  logic [IW-1:0]   idx;
  logic [AW-1:0]   rd, pix_ext, combined, wdata;

  assign in_ready = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign done     = (state == ST_DONE);

  assign ch_last  = (ch  == CHW'(C - 1));
  assign col_last = (col == COLW'(W - 1));
  assign row_last = (row == ROWW'(H - 1));

  // K is a power of two, so the in-window position is the low log2(K) bits.
  assign win_first = (row[KB-1:0] == '0) && (col[KB-1:0] == '0);
  assign win_last  = (row[KB-1:0] == KB'(K - 1)) && (col[KB-1:0] == KB'(K - 1));

  assign idx      = IW'(int'(col >> KB) * C + int'(ch));
  assign pix_ext  = AW'(in_data);
  assign combined = (mode_q == MODE_AVG) ? (rd + pix_ext)
                                         : ((pix_ext > rd) ? pix_ext : rd);
  assign wdata    = win_first ? pix_ext : combined;

  pool_acc_buf #(.AW(AW), .DEPTH(DEPTH), .IW(IW)) u_acc (
    .clk   (clk),
    .we    (accept),
    .waddr (idx),
    .wdata (wdata),
    .raddr (idx),
    .rdata (rd)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state     <= ST_IDLE;
      mode_q    <= MODE_MAX;
      ch        <= '0;
      col       <= '0;
      row       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // A new result can only land when the output slot is free or draining,
      // because in_ready already requires that.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (accept && win_last) begin
        out_valid <= 1'b1;
        out_data  <= (mode_q == MODE_AVG) ? DW'(combined >> SH) : DW'(combined);
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_RUN;
            mode_q <= mode;
            ch     <= '0;
            col    <= '0;
            row    <= '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (ch_last) begin
              ch <= '0;
              if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end else begin
              ch <= ch + 1'b1;
            end
            if (ch_last && col_last && row_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!out_valid || out_ready) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
